// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - instruction fetch stage with IF/ID buffer, flush drain and misalign fault (optional FETCH_TIMEOUT_EN)
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h00400000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FULL  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t state;
  logic   do_launch;
  logic   misaligned;

  // Request is decoded from state so that clearing state drops it asynchronously.
  assign imem_req    = (state == REQ) || (state == DRAIN);
  assign if_pc_plus4 = if_pc + 32'd4;
  assign misaligned  = (pc_in[1:0] != 2'b00);

  // Decide whether this edge starts a new fetch from pc_in.
  always_comb begin
    do_launch = 1'b0;
    case (state)
      IDLE:    do_launch = 1'b1;
      REQ:     do_launch = flush && imem_ack;
      FULL:    do_launch = flush || id_ready;
      DRAIN:   do_launch = imem_ack;
      default: do_launch = 1'b0;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             waiting;
  logic             timed_out;

  assign waiting       = imem_req && !imem_ack;
  assign wait_cnt_next = wait_cnt + 1'b1;
  assign timed_out     = waiting && (wait_cnt_next == CNT_W'(TIMEOUT_CYCLES));

  // Count consecutive unacknowledged request cycles; any ack or exit restarts it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
    end else if (waiting && !timed_out) begin
      wait_cnt <= wait_cnt_next;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  logic timed_out;
  logic unused_timeout;

  assign timed_out      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Fetch FSM: handshake, IF/ID buffer, flush handling and fault capture.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      imem_addr   <= 32'd0;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= RESET_PC;
      pc_advance  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      pc_advance <= 1'b0;
      case (state)
        REQ: begin
          if (flush) begin
            if_valid <= 1'b0;
            if (!imem_ack && !timed_out) begin
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            if_instr   <= imem_rdata;
            if_pc      <= imem_addr;
            if_valid   <= 1'b1;
            pc_advance <= 1'b1;
            state      <= FULL;
          end
        end
        FULL: begin
          if (flush || id_ready) begin
            if_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (timed_out) begin
        fetch_fault <= 1'b1;
        if_valid    <= 1'b0;
        state       <= HALT;
      end else if (do_launch) begin
        imem_addr <= pc_in;
        if (misaligned) begin
          fetch_fault <= 1'b1;
          state       <= HALT;
        end else begin
          state <= REQ;
        end
      end
    end
  end

endmodule
